// File: rtl/xunit_sha2_pkg.sv
// Shared definitions for the SHA-2 compression unit: FSM states, rotation amounts
// for SHA-256/SHA-512, and a width-generic rotate-right helper.
package sha2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_LOAD,
    ST_ROUND,
    ST_FFWD
  } state_t;

  localparam int NWORDS = 8;

  localparam int SHA256_S0_A = 2;
  localparam int SHA256_S0_B = 13;
  localparam int SHA256_S0_C = 22;
  localparam int SHA256_S1_A = 6;
  localparam int SHA256_S1_B = 11;
  localparam int SHA256_S1_C = 25;

  localparam int SHA512_S0_A = 28;
  localparam int SHA512_S0_B = 34;
  localparam int SHA512_S0_C = 39;
  localparam int SHA512_S1_A = 14;
  localparam int SHA512_S1_B = 18;
  localparam int SHA512_S1_C = 41;

  // Rotate the low w bits of x right by n; bits above w come back as zero.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

endpackage

// File: rtl/xunit_sha2_if.sv
// Configuration, data and status bundle of the SHA-2 compression unit.
interface xunit_sha2_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10
);
  logic               run;
  logic               done;
  logic [DATA_W-1:0]  in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic [DATA_W-1:0]  out0, out1, out2, out3, out4, out5, out6, out7;
  logic [DELAY_W-1:0] delay0;
  logic [6:0]         nrounds;
  logic               ffwd;

  modport master (
    output run, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9, delay0, nrounds, ffwd,
    input  done, out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  run, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9, delay0, nrounds, ffwd,
    output done, out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface

// File: rtl/xunit_sha2_round_f.sv
// One combinational SHA-2 round: working state a..h plus W_t/K_t in, next a..h out.
module sha2_round_f
  import sha2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a, b, c, d, e, f, g, h,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] na, nb, nc, nd, ne, nf, ng, nh
);

  localparam int R0A = (DATA_W == 64) ? SHA512_S0_A : SHA256_S0_A;
  localparam int R0B = (DATA_W == 64) ? SHA512_S0_B : SHA256_S0_B;
  localparam int R0C = (DATA_W == 64) ? SHA512_S0_C : SHA256_S0_C;
  localparam int R1A = (DATA_W == 64) ? SHA512_S1_A : SHA256_S1_A;
  localparam int R1B = (DATA_W == 64) ? SHA512_S1_B : SHA256_S1_B;
  localparam int R1C = (DATA_W == 64) ? SHA512_S1_C : SHA256_S1_C;

  function automatic logic [DATA_W-1:0] rot(input logic [DATA_W-1:0] x, input int n);
    return DATA_W'(rotr(64'(x), n, DATA_W));
  endfunction

  logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;

  assign s0  = rot(a, R0A) ^ rot(a, R0B) ^ rot(a, R0C);
  assign s1  = rot(e, R1A) ^ rot(e, R1B) ^ rot(e, R1C);
  assign ch  = (e & f) ^ (~e & g);
  assign maj = (a & b) ^ (a & c) ^ (b & c);
  assign t1  = h + s1 + ch + k + w;
  assign t2  = s0 + maj;

  assign na = t1 + t2;
  assign nb = a;
  assign nc = b;
  assign nd = c;
  assign ne = d + t1;
  assign nf = e;
  assign ng = f;
  assign nh = g;

endmodule

// File: rtl/xunit_sha2.sv
// SHA-2 compression unit: optional start delay, load of a..h, NROUNDS streamed rounds,
// and optional feed-forward of the loaded state so the outputs form the block digest.
module xunit_sha2
  import sha2_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10
) (
  input logic         clk,
  input logic         rst,
  xunit_sha2_if.slave bus
);

  state_t             state, state_nx;
  logic [DELAY_W-1:0] dly_cnt;
  logic [6:0]         rnd_cnt;
  logic [6:0]         nrounds_q;
  logic               ffwd_q;

  logic [DATA_W-1:0]  st  [NWORDS];
  logic [DATA_W-1:0]  sv  [NWORDS];
  logic [DATA_W-1:0]  nxt [NWORDS];
  logic [DATA_W-1:0]  ld  [NWORDS];

  assign ld = '{bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7};

  sha2_round_f #(.DATA_W(DATA_W)) u_round (
    .a (st[0]), .b (st[1]), .c (st[2]), .d (st[3]),
    .e (st[4]), .f (st[5]), .g (st[6]), .h (st[7]),
    .w (bus.in8),
    .k (bus.in9),
    .na(nxt[0]), .nb(nxt[1]), .nc(nxt[2]), .nd(nxt[3]),
    .ne(nxt[4]), .nf(nxt[5]), .ng(nxt[6]), .nh(nxt[7])
  );

  // run has priority in every state so a busy sequence can be aborted and restarted
  always_comb begin
    state_nx = state;
    if (bus.run) begin
      state_nx = (bus.delay0 == '0) ? ST_LOAD : ST_DELAY;
    end else begin
      unique case (state)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_DELAY: if (dly_cnt <= DELAY_W'(1)) state_nx = ST_LOAD;
        ST_LOAD: begin
          if (nrounds_q != 7'd0) state_nx = ST_ROUND;
          else if (ffwd_q)       state_nx = ST_FFWD;
          else                   state_nx = ST_IDLE;
        end
        ST_ROUND: if (rnd_cnt == nrounds_q - 7'd1) state_nx = ffwd_q ? ST_FFWD : ST_IDLE;
        ST_FFWD:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dly_cnt   <= '0;
      rnd_cnt   <= '0;
      nrounds_q <= '0;
      ffwd_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.run) begin
        dly_cnt   <= bus.delay0;
        nrounds_q <= bus.nrounds;
        ffwd_q    <= bus.ffwd;
        rnd_cnt   <= '0;
      end else begin
        case (state)
          ST_DELAY: dly_cnt <= dly_cnt - DELAY_W'(1);
          ST_LOAD:  rnd_cnt <= '0;
          ST_ROUND: rnd_cnt <= rnd_cnt + 7'd1;
          default:  ;
        endcase
      end
    end
  end

  // Working state only moves in LOAD/ROUND/FFWD; a run pulse freezes it until the next LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        st[i] <= '0;
        sv[i] <= '0;
      end
    end else if (!bus.run) begin
      case (state)
        ST_LOAD: begin
          st <= ld;
          sv <= ld;
        end
        ST_ROUND: st <= nxt;
        ST_FFWD: begin
          for (int i = 0; i < NWORDS; i++) st[i] <= st[i] + sv[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.done = (state == ST_IDLE);
  assign bus.out0 = st[0];
  assign bus.out1 = st[1];
  assign bus.out2 = st[2];
  assign bus.out3 = st[3];
  assign bus.out4 = st[4];
  assign bus.out5 = st[5];
  assign bus.out6 = st[6];
  assign bus.out7 = st[7];

endmodule

// File: tb/tb_xunit_sha2.sv
// Bench for xunit_sha2: SHA-256 and SHA-512 instances against known digests and a
// behavioural compression model, plus timing, reset, restart and hold behaviour.
module tb_xunit_sha2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xunit_sha2_if #(.DATA_W(32), .DELAY_W(10)) if32 ();
  xunit_sha2_if #(.DATA_W(64), .DELAY_W(10)) if64 ();

  xunit_sha2 #(.DATA_W(32), .DELAY_W(10)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  xunit_sha2 #(.DATA_W(64), .DELAY_W(10)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  logic        run32, run64, ffc;
  logic [9:0]  dly;
  logic [6:0]  nr;
  logic [63:0] din [10];
  logic [63:0] o32 [8];
  logic [63:0] o64 [8];

  assign if32.run = run32;   assign if64.run = run64;
  assign if32.delay0 = dly;  assign if64.delay0 = dly;
  assign if32.nrounds = nr;  assign if64.nrounds = nr;
  assign if32.ffwd = ffc;    assign if64.ffwd = ffc;
  assign if32.in0 = din[0][31:0];  assign if64.in0 = din[0];
  assign if32.in1 = din[1][31:0];  assign if64.in1 = din[1];
  assign if32.in2 = din[2][31:0];  assign if64.in2 = din[2];
  assign if32.in3 = din[3][31:0];  assign if64.in3 = din[3];
  assign if32.in4 = din[4][31:0];  assign if64.in4 = din[4];
  assign if32.in5 = din[5][31:0];  assign if64.in5 = din[5];
  assign if32.in6 = din[6][31:0];  assign if64.in6 = din[6];
  assign if32.in7 = din[7][31:0];  assign if64.in7 = din[7];
  assign if32.in8 = din[8][31:0];  assign if64.in8 = din[8];
  assign if32.in9 = din[9][31:0];  assign if64.in9 = din[9];

  assign o32[0] = 64'(if32.out0);  assign o64[0] = if64.out0;
  assign o32[1] = 64'(if32.out1);  assign o64[1] = if64.out1;
  assign o32[2] = 64'(if32.out2);  assign o64[2] = if64.out2;
  assign o32[3] = 64'(if32.out3);  assign o64[3] = if64.out3;
  assign o32[4] = 64'(if32.out4);  assign o64[4] = if64.out4;
  assign o32[5] = 64'(if32.out5);  assign o64[5] = if64.out5;
  assign o32[6] = 64'(if32.out6);  assign o64[6] = if64.out6;
  assign o32[7] = 64'(if32.out7);  assign o64[7] = if64.out7;

  logic [63:0] k512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  logic [63:0] iv256 [8] = '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
                             64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
  logic [63:0] dig256 [8] = '{64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
                              64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad};
  logic [63:0] iv512 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                             64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                             64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  logic [63:0] dig512 [8] = '{64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
                              64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                              64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  int checks = 0;
  int failures = 0;
  logic [63:0] wf [80];
  logic [63:0] kf [80];
  logic [63:0] st_init [8];
  logic [63:0] exp_st [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? '1 : 64'h0000_0000_ffff_ffff;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & msk(w);
  endfunction

  // Reference compression: n rounds over st_init with wf/kf, optional feed-forward.
  function automatic void model(input int w, input int n, input bit f);
    logic [63:0] m, t1, t2, bs0, bs1, ch, mj;
    logic [63:0] s [8];
    m = msk(w);
    for (int i = 0; i < 8; i++) s[i] = st_init[i] & m;
    for (int t = 0; t < n; t++) begin
      bs0 = (w == 64) ? rr(s[0], 28, w) ^ rr(s[0], 34, w) ^ rr(s[0], 39, w)
                      : rr(s[0], 2, w) ^ rr(s[0], 13, w) ^ rr(s[0], 22, w);
      bs1 = (w == 64) ? rr(s[4], 14, w) ^ rr(s[4], 18, w) ^ rr(s[4], 41, w)
                      : rr(s[4], 6, w) ^ rr(s[4], 11, w) ^ rr(s[4], 25, w);
      ch = (s[4] & s[5]) ^ (~s[4] & s[6]);
      mj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
      t1 = (s[7] + bs1 + ch + kf[t] + wf[t]) & m;
      t2 = (bs0 + mj) & m;
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = (s[4] + t1) & m;
      s[0] = (t1 + t2) & m;
    end
    for (int i = 0; i < 8; i++) exp_st[i] = f ? ((s[i] + (st_init[i] & m)) & m) : s[i];
  endfunction

  // Message schedule and constants for the single padded block of "abc".
  function automatic void sched_abc(input int w);
    logic [63:0] m, x0, x1;
    m = msk(w);
    for (int t = 0; t < 16; t++) wf[t] = 64'd0;
    wf[0]  = (w == 64) ? 64'h6162638000000000 : 64'h61626380;
    wf[15] = 64'd24;
    for (int t = 16; t < 80; t++) begin
      x0 = (w == 64) ? rr(wf[t-15], 1, w) ^ rr(wf[t-15], 8, w) ^ (wf[t-15] >> 7)
                     : rr(wf[t-15], 7, w) ^ rr(wf[t-15], 18, w) ^ (wf[t-15] >> 3);
      x1 = (w == 64) ? rr(wf[t-2], 19, w) ^ rr(wf[t-2], 61, w) ^ (wf[t-2] >> 6)
                     : rr(wf[t-2], 17, w) ^ rr(wf[t-2], 19, w) ^ (wf[t-2] >> 10);
      wf[t] = (x1 + wf[t-7] + x0 + wf[t-16]) & m;
    end
    for (int t = 0; t < 80; t++) kf[t] = (w == 64) ? k512[t] : (k512[t] >> 32);
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel != 0) ? if64.done : if32.done;
  endfunction

  function automatic logic [63:0] sel_out(input int sel, input int i);
    return (sel != 0) ? o64[i] : o32[i];
  endfunction

  task automatic check_out(input int sel, input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_out%0d", tag, i), sel_out(sel, i), exp_st[i]);
  endtask

  // Pulse run, then feed W/K only on the edges where rounds are due (garbage otherwise).
  // Returns the number of edges after the run edge until done, or -1 if stopped/timed out.
  task automatic run_block(input int sel, input int d, input int n, input bit f,
                           input int stop_at, output int lat);
    int e, idx;
    dly = 10'(d);
    nr  = 7'(n);
    ffc = f;
    for (int i = 0; i < 8; i++) din[i] = st_init[i];
    if (sel != 0) run64 = 1'b1; else run32 = 1'b1;
    @(posedge clk); #1;
    run32 = 1'b0;
    run64 = 1'b0;
    e = 0;
    lat = -1;
    while (e < 400) begin
      if (stop_at >= 0 && e == stop_at) break;
      if (sel_done(sel)) begin
        lat = e;
        break;
      end
      idx = e + 1 - (d + 2);
      if (idx >= 0 && idx < n) begin
        din[8] = wf[idx];
        din[9] = kf[idx];
      end else begin
        din[8] = {$urandom, $urandom};
        din[9] = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      if (e + 1 == d + 1) for (int i = 0; i < 8; i++) din[i] = {$urandom, $urandom};
      e++;
    end
  endtask

  initial begin
    int lat, sel, d, n;
    bit f;
    logic [63:0] m;
    rst = 1'b1;
    run32 = 1'b0;
    run64 = 1'b0;
    dly = '0;
    nr = '0;
    ffc = 1'b0;
    for (int i = 0; i < 10; i++) din[i] = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) exp_st[i] = 64'd0;
    chk("reset_done32", 64'(if32.done), 64'd1);
    chk("reset_done64", 64'(if64.done), 64'd1);
    check_out(0, "reset32");
    check_out(1, "reset64");
    rst = 1'b0;

    // SHA-256 "abc", no delay, with feed-forward
    sched_abc(32);
    for (int i = 0; i < 8; i++) st_init[i] = iv256[i];
    run_block(0, 0, 64, 1'b1, -1, lat);
    chk("sha256_latency", 64'(lat), 64'd66);
    for (int i = 0; i < 8; i++) exp_st[i] = dig256[i];
    check_out(0, "sha256_abc");

    // Asynchronous reset in the middle of the rounds
    run_block(0, 0, 64, 1'b1, 10, lat);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) exp_st[i] = 64'd0;
    chk("rst_mid_done", 64'(if32.done), 64'd1);
    check_out(0, "rst_mid");
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_after_done", 64'(if32.done), 64'd1);
    check_out(0, "rst_after");

    // SHA-512 "abc"
    sched_abc(64);
    for (int i = 0; i < 8; i++) st_init[i] = iv512[i];
    run_block(1, 0, 80, 1'b1, -1, lat);
    chk("sha512_latency", 64'(lat), 64'd82);
    for (int i = 0; i < 8; i++) exp_st[i] = dig512[i];
    check_out(1, "sha512_abc");

    // Delay 3, one round, no feed-forward, zero state, W=1 K=0
    for (int i = 0; i < 8; i++) st_init[i] = 64'd0;
    wf[0] = 64'd1;
    kf[0] = 64'd0;
    run_block(0, 3, 1, 1'b0, -1, lat);
    chk("delay3_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 8; i++) exp_st[i] = 64'd0;
    exp_st[0] = 64'd1;
    exp_st[4] = 64'd1;
    check_out(0, "delay3");

    // Zero rounds with feed-forward doubles the loaded state
    for (int i = 0; i < 8; i++) st_init[i] = 64'(i + 1);
    run_block(1, 2, 0, 1'b1, -1, lat);
    chk("zero_rounds_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 8; i++) exp_st[i] = 64'(2 * (i + 1));
    check_out(1, "zero_rounds");

    // Restart while busy: abort mid-ROUND, hold through a new DELAY, then a clean run
    sched_abc(32);
    for (int i = 0; i < 8; i++) st_init[i] = iv256[i];
    run_block(0, 0, 64, 1'b1, 30, lat);
    for (int i = 0; i < 8; i++) exp_st[i] = o32[i];
    run_block(0, 3, 64, 1'b1, 2, lat);
    check_out(0, "restart_hold");
    run_block(0, 0, 64, 1'b1, -1, lat);
    chk("restart_latency", 64'(lat), 64'd66);
    for (int i = 0; i < 8; i++) exp_st[i] = dig256[i];
    check_out(0, "restart_abc");

    // Randomised blocks against the reference model
    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(0, 1));
      d   = int'($urandom_range(0, 4));
      n   = (r == 0) ? 0 : int'($urandom_range(1, 12));
      f   = 1'($urandom_range(0, 1));
      m   = msk(sel != 0 ? 64 : 32);
      for (int i = 0; i < 8; i++) st_init[i] = {$urandom, $urandom} & m;
      for (int t = 0; t < 80; t++) begin
        wf[t] = {$urandom, $urandom} & m;
        kf[t] = {$urandom, $urandom} & m;
      end
      model(sel != 0 ? 64 : 32, n, f);
      run_block(sel, d, n, f, -1, lat);
      chk($sformatf("rand%0d_latency", r), 64'(lat), 64'(d + 1 + n + (f ? 1 : 0)));
      check_out(sel, $sformatf("rand%0d", r));
    end

    // Outputs hold while idle regardless of input activity
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) din[i] = {$urandom, $urandom};
      @(posedge clk);
    end
    #1;
    chk("idle_hold_done", 64'(sel_done(sel)), 64'd1);
    check_out(sel, "idle_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
